// File: rtl/pdm_deserializer.sv
// -----------------------------------------------------------------------------
// pdm_deserializer
//
// Capture stage for a PDM microphone. It derives the microphone clock from the
// system clock and samples the 1-bit PDM stream on each falling m_clk edge. The
// stream becomes a PCM amplitude by counting ones over two windows of WINDOW
// samples each. The second window is offset from the first by WINDOW/2 samples,
// so one amplitude is produced every WINDOW/2 m_clk periods.
//
// Parameters
//   CLK_FREQ   system clock frequency in MHz
//   MCLK_FREQ  microphone clock frequency in kHz. CLK_FREQ*1000/(2*MCLK_FREQ)
//              must be an integer >= 2.
//   WINDOW     PDM samples per window. Must be a power of 2 and >= 4.
//
// Ports
//   clk              in   system clock
//   rst_n            in   synchronous reset, active low
//   m_clk            out  microphone clock, 50% duty
//   m_clk_rise       out  1-clk pulse in the cycle m_clk goes 0->1
//   m_data           in   PDM data, valid from the rising edge of m_clk
//   amplitude        out  ones count of the last completed window, 0..WINDOW
//   amplitude_valid  out  1-clk pulse when amplitude updates
// -----------------------------------------------------------------------------
module pdm_deserializer #(
  parameter int unsigned CLK_FREQ  = 100,
  parameter int unsigned MCLK_FREQ = 2500,
  parameter int unsigned WINDOW    = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       m_clk,
  output logic                       m_clk_rise,
  input  logic                       m_data,
  output logic [$clog2(WINDOW):0]    amplitude,
  output logic                       amplitude_valid
);

  localparam int unsigned HALF  = (CLK_FREQ * 1000) / (2 * MCLK_FREQ);
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned IDX_W = $clog2(WINDOW);
  localparam int unsigned AMP_W = IDX_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_MID   = IDX_W'(WINDOW / 2);
  localparam logic [IDX_W-1:0] IDX_MID_M = IDX_W'(WINDOW / 2 - 1);

  // The B window is one half-window behind A. The first B close after reset
  // has seen only half a window, so it is dropped. This FSM tracks whether that
  // first close has already happened.
  typedef enum logic {
    PRIME_WAIT,
    PRIME_DONE
  } prime_state_t;

  prime_state_t r_prime_state;
  prime_state_t w_prime_next;

  // Clock divider and microphone clock
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_m_clk;
  logic             r_m_clk_rise;
  logic             w_div_wrap;
  logic             w_capture;

  // Capture pipeline
  logic             r_m_data_q;
  logic             r_cap_q;
  logic [IDX_W-1:0] r_s_idx;

  // Window accumulators
  logic [AMP_W-1:0] r_acc_a;
  logic [AMP_W-1:0] r_acc_b;
  logic [AMP_W-1:0] w_data_ext;
  logic             r_close_a;
  logic             r_close_b;
  logic             w_emit_b;

  // Output registers
  logic [AMP_W-1:0] r_amplitude;
  logic             r_amplitude_valid;

  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  // The capture edge is the cycle in which m_clk toggles from 1 to 0.
  assign w_capture  = w_div_wrap & r_m_clk;
  assign w_data_ext = AMP_W'(r_m_data_q);

  // ---------------------------------------------------------------------------
  // Divider: m_clk toggles every HALF system clocks
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_m_clk      <= 1'b0;
      r_m_clk_rise <= 1'b0;
    end else begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_m_clk   <= ~r_m_clk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      r_m_clk_rise <= w_div_wrap & ~r_m_clk;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture: register m_data on the capture edge, then flag it for one cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_data_q <= 1'b0;
      r_cap_q    <= 1'b0;
    end else begin
      r_cap_q <= w_capture;
      if (w_capture) begin
        r_m_data_q <= m_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators and sample index
  //
  // The index advances in the same cycle the accumulators consume the sample.
  // While r_cap_q is high, r_s_idx is still the index of the sample just
  // captured. The close flags are set here, and the close is seen one cycle
  // later, when the accumulators already hold the complete count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_idx   <= '0;
      r_acc_a   <= '0;
      r_acc_b   <= '0;
      r_close_a <= 1'b0;
      r_close_b <= 1'b0;
    end else begin
      r_close_a <= 1'b0;
      r_close_b <= 1'b0;
      if (r_cap_q) begin
        r_s_idx <= r_s_idx + 1'b1;

        if (r_s_idx == '0) begin
          r_acc_a <= w_data_ext;
        end else begin
          r_acc_a <= r_acc_a + w_data_ext;
        end

        if (r_s_idx == IDX_MID) begin
          r_acc_b <= w_data_ext;
        end else begin
          r_acc_b <= r_acc_b + w_data_ext;
        end

        r_close_a <= (r_s_idx == IDX_LAST);
        r_close_b <= (r_s_idx == IDX_MID_M);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Priming FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prime_state <= PRIME_WAIT;
    end else begin
      r_prime_state <= w_prime_next;
    end
  end

  always_comb begin
    w_prime_next = r_prime_state;
    w_emit_b     = 1'b0;
    case (r_prime_state)
      PRIME_WAIT: begin
        if (r_close_b) begin
          w_prime_next = PRIME_DONE;
        end
      end
      PRIME_DONE: begin
        w_emit_b = r_close_b;
      end
      default: begin
        w_prime_next = PRIME_WAIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output: the A and B closes are WINDOW/2 samples apart, so at most one of
  // them is active in any cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_amplitude       <= '0;
      r_amplitude_valid <= 1'b0;
    end else begin
      r_amplitude_valid <= 1'b0;
      if (r_close_a) begin
        r_amplitude       <= r_acc_a;
        r_amplitude_valid <= 1'b1;
      end else if (w_emit_b) begin
        r_amplitude       <= r_acc_b;
        r_amplitude_valid <= 1'b1;
      end
    end
  end

  assign m_clk           = r_m_clk;
  assign m_clk_rise      = r_m_clk_rise;
  assign amplitude       = r_amplitude;
  assign amplitude_valid = r_amplitude_valid;

endmodule

// File: tb/tb_pdm_deserializer.sv
// -----------------------------------------------------------------------------
// tb_pdm_deserializer
//
// Bench for pdm_deserializer at its default parameters. A new PDM bit is driven
// on each m_clk rise predicted by a local divider model. A window of the driven
// bits is kept, and each expected window count is queued together with the
// cycle in which it must appear. Those expectations are popped and compared as
// the cycles pass.
// -----------------------------------------------------------------------------
module tb_pdm_deserializer;

  localparam int HALF = 20;
  localparam int WIN  = 128;

  typedef struct {
    int amp;
    int due;
    bit tol;
    int lvl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_data = 1'b0;
  logic       m_clk;
  logic       m_clk_rise;
  logic [7:0] amplitude;
  logic       amplitude_valid;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int          cyc = 0;
  int          n = 0;          // clk edges since reset release
  int          k = 0;          // samples driven since reset release
  int          last_amp = 0;
  int          mode = 0;
  int          level = 0;
  int          lvl_start = 0;
  int          mod_acc = 0;
  bit          hist[$];
  exp_t        q[$];

  always #5 clk = ~clk;

  pdm_deserializer #(
    .CLK_FREQ (100),
    .MCLK_FREQ(2500),
    .WINDOW   (128)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m_clk          (m_clk),
    .m_clk_rise     (m_clk_rise),
    .m_data         (m_data),
    .amplitude      (amplitude),
    .amplitude_valid(amplitude_valid)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, n %0d)", tag, obs, exp_v, cyc, n);
    end
  endtask

  // Advance one clock, check outputs #1 after the edge, and drive the next PDM
  // bit when the model predicts an m_clk rise.
  task automatic step();
    bit   r;
    bit   b;
    int   exp_mclk;
    int   exp_rise;
    bit   exp_v;
    int   sum;
    int   d;
    exp_t e;
    r = rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (r) n++;
    else   n = 0;

    exp_mclk = (n / HALF) % 2;
    exp_rise = (n % (2 * HALF) == HALF) ? 1 : 0;
    check("m_clk", int'(m_clk), exp_mclk);
    check("m_clk_rise", int'(m_clk_rise), exp_rise);

    exp_v = (q.size() > 0) && (q[0].due == n);
    if (amplitude_valid || exp_v)
      check("amp_valid", int'(amplitude_valid), int'(exp_v));
    if (exp_v) begin
      e = q.pop_front();
      check("amplitude", int'(amplitude), e.amp);
      if (e.tol) begin
        d = int'(amplitude) - e.lvl;
        if (d < 0) d = -d;
        check("amp_tol", (d <= 1) ? 1 : 0, 1);
      end
      last_amp = e.amp;
    end else begin
      check("amp_hold", int'(amplitude), last_amp);
    end

    if (exp_rise == 1) begin
      case (mode)
        0: b = 1'b1;
        1: b = 1'b0;
        2: b = (k % 2 == 0);
        3: b = (k < 64);
        4: begin
          sum     = mod_acc + level;
          b       = (sum >= 128);
          mod_acc = sum % 128;
        end
        default: b = bit'($urandom_range(1, 0));
      endcase
      m_data = b;
      hist.push_back(b);
      if (hist.size() > WIN) void'(hist.pop_front());
      if ((k % (WIN / 2) == WIN / 2 - 1) && (k >= WIN - 1)) begin
        sum = 0;
        foreach (hist[i]) sum += int'(hist[i]);
        e.amp = sum;
        e.due = n + HALF + 2;
        e.tol = (mode == 4) && (k - (WIN - 1) >= lvl_start);
        e.lvl = level;
        q.push_back(e);
      end
      k++;
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst_n     = 1'b0;
    m_data    = 1'b1;
    q.delete();
    hist.delete();
    k         = 0;
    last_amp  = 0;
    mod_acc   = 0;
    lvl_start = 0;
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  task automatic run_samples(input int target);
    int guard;
    guard = 0;
    while (k < target && guard < (target + 2) * 2 * HALF + 100) begin
      step();
      guard++;
    end
    if (k < target) check("sample_timeout", k, target);
  endtask

  task automatic drain();
    repeat (2 * HALF) step();
    check("drain", q.size(), 0);
  endtask

  initial begin
    // Constant ones
    mode = 0;
    apply_reset(4);
    run_samples(192);
    drain();

    // Constant zeros
    mode = 1;
    apply_reset(4);
    run_samples(192);
    drain();

    // Alternating 1,0
    mode = 2;
    apply_reset(4);
    run_samples(192);
    drain();

    // Ones for samples 0..63, zeros afterwards
    mode = 3;
    apply_reset(4);
    run_samples(256);
    drain();

    // Random stream
    mode = 5;
    apply_reset(4);
    run_samples(192);
    drain();

    // Reset at sample 100: earlier counts are discarded
    mode = 5;
    apply_reset(4);
    run_samples(101);
    apply_reset(3);
    run_samples(192);
    drain();

    // First-order sigma-delta source at densities 32, 64, 96 of 128
    mode = 4;
    apply_reset(4);
    level = 32; lvl_start = 0;
    run_samples(192);
    level = 64; lvl_start = 192;
    run_samples(384);
    level = 96; lvl_start = 384;
    run_samples(576);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
